// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// State encoding, HALT opcode and the default NOP encoding used for an empty slot.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

  localparam logic [4:0]  OPC_HALT      = 5'b00000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  function automatic logic isHalt(input logic [15:0] instr);
    return instr[15:11] == OPC_HALT;
  endfunction

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: 4-bit groups with a second-level group carry lookahead.
module cla_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S
);

  logic [14:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  grpG;
  logic [2:0]  grpP;
  logic [3:0]  gc;

  always_comb begin
    g = A[14:0] & B[14:0];
    p = A ^ B;
    // Group generate/propagate only for the three groups that feed a higher carry.
    for (int unsigned k = 0; k < 3; k++) begin
      grpG[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grpP[k] = &p[4*k +: 4];
    end
    gc[0] = C_in;
    gc[1] = grpG[0] | (grpP[0] & gc[0]);
    gc[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & gc[0]);
    gc[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
          | (grpP[2] & grpP[1] & grpP[0] & gc[0]);
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    S = p ^ c;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding imem request at a time,
// and presents a registered instruction slot to decode with stall, redirect and HALT handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic        halted
);

  fetchState_t stateQ, stateD;
  logic [15:0] pcQ, pcD, pcPlus2;
  logic [15:0] instrD, ifPcD, ifPc2D;
  logic        validD, haltedD, accept, load;

  cla_16b u_pcAdd (
    .A    (pcQ),
    .B    (16'h0002),
    .C_in (1'b0),
    .S    (pcPlus2)
  );

  assign imem_addr = pcQ;
  assign imem_en   = (stateQ == REQ) && (!if_valid || !stall) && !rst;
  assign accept    = imem_en && !imem_stall;

  always_comb begin
    stateD  = stateQ;
    pcD     = pcQ;
    haltedD = halted;
    validD  = if_valid;
    instrD  = if_instr;
    ifPcD   = if_pc;
    ifPc2D  = if_pc_plus2;
    load    = 1'b0;

    if (if_valid && !stall) begin
      validD = 1'b0;
      instrD = NOP_INSTR;
    end

    if (redirect_en) begin
      // DRAIN is entered whenever a request is still in flight after this edge.
      pcD    = redirect_pc;
      validD = 1'b0;
      instrD = NOP_INSTR;
      case (stateQ)
        REQ:         stateD = (accept && !imem_done) ? DRAIN : REQ;
        WAIT, DRAIN: stateD = imem_done ? REQ : DRAIN;
        HALT: begin
          stateD  = REQ;
          haltedD = 1'b0;
        end
        default:     stateD = REQ;
      endcase
    end else begin
      case (stateQ)
        REQ: begin
          if (accept) begin
            if (imem_done) load = 1'b1;
            else           stateD = WAIT;
          end
        end
        WAIT:    if (imem_done) load = 1'b1;
        DRAIN:   if (imem_done) stateD = REQ;
        default: ;
      endcase

      if (load) begin
        instrD = imem_data;
        ifPcD  = pcQ;
        ifPc2D = pcPlus2;
        validD = 1'b1;
        pcD    = pcPlus2;
        if (isHalt(imem_data)) begin
          stateD  = HALT;
          haltedD = 1'b1;
        end else begin
          stateD = REQ;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= REQ;
      pcQ         <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus2 <= '0;
      halted      <= 1'b0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      if_valid    <= validD;
      if_instr    <= instrD;
      if_pc       <= ifPcD;
      if_pc_plus2 <= ifPc2D;
      halted      <= haltedD;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vectors give the inputs held across the next
// edge and the outputs expected during that cycle, before the edge.
module tb_fetch_ctrl;

  typedef struct {
    logic        rst, stall, rdEn;
    logic [15:0] rdPc;
    logic        mStall, mDone;
    logic [15:0] mData;
    logic        eEn;
    logic [15:0] eAddr;
    logic        eValid;
    logic [15:0] eInstr, ePc;
    logic        eHalted;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_en, imem_stall, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_en, if_valid, halted;
  logic [15:0] imem_addr, if_instr, if_pc, if_pc_plus2;

  int nCmp = 0;
  int nBad = 0;
  vec_t vecs[$];

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_stall  (imem_stall),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .if_valid    (if_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic re, input logic [15:0] rp,
                              input logic ms, input logic md, input logic [15:0] d,
                              input logic en, input logic [15:0] a, input logic v,
                              input logic [15:0] ins, input logic [15:0] pc, input logic h);
    vec_t t;
    t.rst = r; t.stall = s; t.rdEn = re; t.rdPc = rp; t.mStall = ms; t.mDone = md; t.mData = d;
    t.eEn = en; t.eAddr = a; t.eValid = v; t.eInstr = ins; t.ePc = pc; t.eHalted = h;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic runRow(input int row, input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = v.stall; redirect_en = v.rdEn; redirect_pc = v.rdPc;
    imem_stall = v.mStall; imem_done = v.mDone; imem_data = v.mData;
    #1;
    chk("imem_en",   row, {15'd0, imem_en},  {15'd0, v.eEn});
    chk("imem_addr", row, imem_addr,         v.eAddr);
    chk("if_valid",  row, {15'd0, if_valid}, {15'd0, v.eValid});
    chk("if_instr",  row, if_instr,          v.eInstr);
    chk("if_pc",     row, if_pc,             v.ePc);
    chk("halted",    row, {15'd0, halted},   {15'd0, v.eHalted});
    if (v.eValid) chk("if_pc_plus2", row, if_pc_plus2, v.ePc + 16'd2);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    imem_stall = 1'b0; imem_done = 1'b0; imem_data = '0;

    //             rst st rd rdPc     ms md data       en addr     v  instr    pc       h
    // reset state, then zero-latency stream 0,2,4,6
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA002, 1, 16'h0002, 1, 16'hA000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA004, 1, 16'h0004, 1, 16'hA002, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA006, 1, 16'h0006, 1, 16'hA004, 16'h0004, 0));
    // 3-cycle latency: one request per 4 cycles
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'hA006, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0008, 0, 16'h0800, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0008, 0, 16'h0800, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA008, 0, 16'h0008, 0, 16'h0800, 16'h0006, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h000A, 1, 16'hA008, 16'h0008, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h000A, 0, 16'h0800, 16'h0008, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h000A, 0, 16'h0800, 16'h0008, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA00A, 0, 16'h000A, 0, 16'h0800, 16'h0008, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA00C, 1, 16'h000C, 1, 16'hA00A, 16'h000A, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA00E, 1, 16'h000E, 1, 16'hA00C, 16'h000C, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA010, 1, 16'h0010, 1, 16'hA00E, 16'h000E, 0));
    // decode stall for 3 cycles holding pc 0x0010
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0012, 1, 16'hA010, 16'h0010, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0012, 1, 16'hA010, 16'h0010, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0012, 1, 16'hA010, 16'h0010, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA012, 1, 16'h0012, 1, 16'hA010, 16'h0010, 0));
    // memory busy: request held, slot still drains
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0014, 1, 16'hA012, 16'h0012, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0014, 0, 16'h0800, 16'h0012, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA014, 0, 16'h0014, 0, 16'h0800, 16'h0012, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0016, 1, 16'hA014, 16'h0014, 0));
    // redirect while WAIT -> DRAIN, late data dropped, refetch at 0x0100
    vecs.push_back(mk(0, 0, 1, 16'h0100, 0, 0, 16'h0000, 0, 16'h0016, 0, 16'h0800, 16'h0014, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0100, 0, 16'h0800, 16'h0014, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0100, 0, 16'h0800, 16'h0014, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA100, 1, 16'h0100, 0, 16'h0800, 16'h0014, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0102, 1, 16'hA100, 16'h0100, 0));
    // redirect coinciding with done in WAIT: straight back to REQ, data dropped
    vecs.push_back(mk(0, 0, 1, 16'h0020, 0, 1, 16'hC0DE, 0, 16'h0102, 0, 16'h0800, 16'h0100, 0));
    // HALT fetched at 0x0020, then redirect to 0x0040 recovers
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0020, 0, 16'h0800, 16'h0100, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0022, 1, 16'h0000, 16'h0020, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0022, 0, 16'h0800, 16'h0020, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 0, 16'h0000, 0, 16'h0022, 0, 16'h0800, 16'h0020, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA040, 1, 16'h0040, 0, 16'h0800, 16'h0020, 0));
    // redirect and stall together: flush wins; then PC wrap at 0xFFFE
    vecs.push_back(mk(0, 1, 1, 16'hFFFE, 0, 0, 16'h0000, 0, 16'h0042, 1, 16'hA040, 16'h0040, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA0FE, 1, 16'hFFFE, 0, 16'h0800, 16'h0040, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hA0FE, 16'hFFFE, 0));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) runRow(i, vecs[i]);

    // Reset asserted mid-WAIT (outstanding at 0x0002); response arriving during reset is ignored.
    runRow(100, mk(0, 0, 0, 16'h0000, 0, 1, 16'hA000, 0, 16'h0000, 0, 16'h0800, 16'hFFFE, 0));
    runRow(101, mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'hA000, 16'h0000, 0));
    runRow(102, mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 0, 16'h0800, 16'h0000, 0));
    runRow(103, mk(1, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0));
    runRow(104, mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0));
    runRow(105, mk(0, 0, 0, 16'h0000, 0, 1, 16'hA000, 0, 16'h0000, 0, 16'h0800, 16'h0000, 0));
    runRow(106, mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'hA000, 16'h0000, 0));

    // Redirect while REQ is accepted without done: request in flight, so DRAIN.
    runRow(200, mk(0, 0, 0, 16'h0000, 0, 1, 16'hA002, 0, 16'h0002, 0, 16'h0800, 16'h0000, 0));
    runRow(201, mk(0, 0, 1, 16'h0200, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'hA002, 16'h0002, 0));
    runRow(202, mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0200, 0, 16'h0800, 16'h0002, 0));
    runRow(203, mk(0, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 16'h0200, 0, 16'h0800, 16'h0002, 0));
    runRow(204, mk(0, 0, 0, 16'h0000, 0, 1, 16'hA200, 1, 16'h0200, 0, 16'h0800, 16'h0002, 0));
    runRow(205, mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0202, 1, 16'hA200, 16'h0200, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the PC register and drives a stall-capable instruction memory with one outstanding request. It presents a registered instruction slot to decode and honours the decode/hazard stall. It flushes and redirects on branch/jump resolution and stops fetching once a HALT has been fetched. It sits between the PC-redirect logic of execute and the IF/ID boundary.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding driven on if_instr when the slot is empty

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept; holds the output slot
redirect_en  in  1  taken branch/jump resolved; flush and refetch
redirect_pc  in  16  redirect target
imem_en  out  1  request valid to instruction memory
imem_addr  out  16  request address
imem_stall  in  1  memory busy; request not accepted this cycle
imem_done  in  1  response valid this cycle
imem_data  in  16  response instruction, valid with imem_done
if_instr  out  16  fetched instruction (registered)
if_pc  out  16  address of if_instr
if_pc_plus2  out  16  if_pc + 2
if_valid  out  1  slot holds a live instruction
halted  out  1  HALT fetched; fetch stopped

Behaviour:
- Reset: rst has priority over all inputs. Values: pc_q=RESET_PC, state=REQ, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus2=0, squash=0, halted=0, imem_en=0 while rst=1.
- Slot consume: slot consumed at an edge when if_valid && !stall.
- imem_addr = pc_q always. imem_en = (state==REQ) && (!if_valid || !stall) && !rst.
- Request acceptance: a request is accepted when imem_en && !imem_stall.
- Response timing: imem_done may arrive in the acceptance cycle (hit) or any later cycle. Only one request is ever outstanding. if_valid is always 0 in WAIT, so no skid buffer is needed.
- State REQ:
  - Accepted with imem_done: load slot, stay in REQ. Throughput is 1 instr/cycle on hits.
  - Accepted without imem_done: go to WAIT.
- State WAIT: imem_en=0. On imem_done, load slot and go to REQ.
- Slot load: if_instr=imem_data, if_pc=pc_q, if_pc_plus2=pc_q+2, if_valid=1, pc_q<=pc_q+2.
- PC arithmetic: 16-bit modulo arithmetic, so 16'hFFFE+2 = 16'h0000.
- HALT: a loaded instruction with [15:11]==5'b00000 is passed downstream as a valid instruction. State goes to HALT and halted=1. In HALT, imem_en=0 and pc_q is held.
- DRAIN: squash=1 and imem_en=0. On imem_done, data is discarded, squash clears and state goes to REQ.
- Redirect (priority below rst, above everything else):
  - Always: pc_q<=redirect_pc, if_valid<=0, if_instr<=NOP_INSTR.
  - No request outstanding after this edge (REQ with no acceptance, acceptance coinciding with imem_done, or WAIT with imem_done): response data dropped, go to REQ.
  - Request still outstanding (WAIT without imem_done, or REQ accepted without done): go to DRAIN.
  - From HALT: halted<=0, go to REQ. A HALT in a branch shadow is recoverable.
  - From DRAIN: update pc_q, stay in DRAIN.
- stall with an empty slot has no effect. stall never blocks a redirect.
- Redirect and stall together: the flush wins and the slot empties.

Decomposition:
- Shared package: state encoding (REQ, WAIT, DRAIN, HALT as a 2-bit enum), OPC_HALT=5'b00000, NOP_INSTR constant.
- PC+2: the codebase's cla_16b adder with B=16'h2 and C_in=0, instantiated once. No other sub-module; FSM and slot register stay in this module.

Test Plan:
- Zero-latency memory, stall=0, rst released: imem_addr 0,2,4,6 on consecutive cycles. if_pc follows one cycle later, if_valid held high, if_pc_plus2 = if_pc+2.
- 3-cycle memory latency: one request per 4 cycles. imem_en low in WAIT. if_valid pulses one cycle per instruction.
- stall=1 for 3 cycles with if_valid=1 (if_pc=0x0010): if_instr/if_pc held, imem_en=0. After release, next fetch at 0x0012.
- redirect_en to 0x0100 while in WAIT: state DRAIN. Late imem_done data dropped (if_valid stays 0). Next imem_addr=0x0100.
- Fetch 16'h0000 at pc 0x0020: if_instr=0x0000 valid once, halted=1, imem_en stays 0. Then redirect to 0x0040: halted=0, fetch resumes at 0x0040.
- pc_q=0xFFFE fetch: if_pc_plus2=0x0000 and next imem_addr=0x0000. Assert rst mid-WAIT: all outputs at reset values, first request at RESET_PC.
